// File: rtl/uart_softmax_frame_tx.sv
// Host-side UART frame sender: a length byte followed by WORDS 16-bit words,
// low byte first, each byte sent as 8N1 on a registered, idle-high txd line.
// Words are loaded through a write port while idle. A start pulse sends one frame.
module uart_softmax_frame_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int WORDS          = 64,
  parameter int INTER_BYTE_GAP = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(WORDS)-1:0]   wr_addr,
  input  logic [15:0]                wr_data,
  input  logic [7:0]                 payload_len,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_reject,
  output logic                       txd
);

  localparam int AW = $clog2(WORDS);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (INTER_BYTE_GAP > 1) ? $clog2(INTER_BYTE_GAP) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(INTER_BYTE_GAP - 1);
  localparam logic [7:0]    LAST_IDX  = 8'(2 * WORDS);
  localparam logic [7:0]    WORDS_B   = 8'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      len_q, len_d;
  logic            txd_q, txd_d;
  logic            wr_reject_q;
  logic [15:0]     buf_q [WORDS];

  logic [WORDS-1:0] word_we;
  logic             wr_ok;
  logic [7:0]       eff_len;
  logic [7:0]       word_k;
  logic [15:0]      fetch_word;
  logic [7:0]       fetch_byte;

  // Idle and the single done cycle both count as not busy.
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign wr_reject = wr_reject_q;
  assign txd       = txd_q;
  assign wr_ok     = wr_en && !busy;

  // One write-enable per buffer word.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_we
    assign word_we[gi] = wr_ok && (wr_addr == AW'(gi));
  end

  // Buffer words; cleared by reset so a post-reset frame carries zeros.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (rst) begin
        buf_q[i] <= '0;
      end else if (word_we[i]) begin
        buf_q[i] <= wr_data;
      end
    end
  end

  // Byte selection: header is the raw length; words past the clamped length are zero.
  assign eff_len    = (len_q == 8'd0 || len_q > WORDS_B) ? WORDS_B : len_q;
  assign word_k     = (byte_idx_q - 8'd1) >> 1;
  assign fetch_word = (word_k < eff_len) ? buf_q[word_k[AW-1:0]] : 16'h0000;
  assign fetch_byte = (byte_idx_q == 8'd0) ? len_q :
                      (byte_idx_q[0] ? fetch_word[7:0] : fetch_word[15:8]);

  // Next-state logic for the framing FSM; txd is derived from the next state so it is a clean flop.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    len_d      = len_q;
    txd_d      = 1'b1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          len_d      = payload_len;
          byte_idx_d = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        shift_d = fetch_byte;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (byte_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
            if (INTER_BYTE_GAP > 0) begin
              gap_d   = '0;
              state_d = S_GAP;
            end else begin
              state_d = S_LOAD;
            end
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_LOAD;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_START) begin
      txd_d = 1'b0;
    end else if (state_d == S_DATA) begin
      txd_d = shift_d[0];
    end
  end

  // State, counters and the registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      len_q       <= '0;
      txd_q       <= 1'b1;
      wr_reject_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      gap_q       <= gap_d;
      bit_q       <= bit_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      len_q       <= len_d;
      txd_q       <= txd_d;
      wr_reject_q <= wr_en && busy;
    end
  end

endmodule

// File: tb/tb_uart_softmax_frame_tx.sv
// Bench for uart_softmax_frame_tx: two instances (no gap / gap of 3) share stimulus;
// UART monitors decode txd and frames are compared with a word-buffer reference model.
module tb_uart_softmax_frame_tx;

  localparam int C  = 4;
  localparam int W  = 64;
  localparam int NB = 1 + 2 * W;
  localparam int P0 = 10 * C + 1;
  localparam int P1 = 10 * C + 1 + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  payload_len = '0;
  logic        start = 1'b0;
  logic        busy0, done0, rej0, txd0;
  logic        busy1, done1, rej1, txd1;

  always #5 clk = ~clk;

  uart_softmax_frame_tx #(.CLKS_PER_BIT(C), .WORDS(W), .INTER_BYTE_GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .payload_len(payload_len), .start(start), .busy(busy0), .done(done0),
    .wr_reject(rej0), .txd(txd0)
  );

  uart_softmax_frame_tx #(.CLKS_PER_BIT(C), .WORDS(W), .INTER_BYTE_GAP(3)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .payload_len(payload_len), .start(start), .busy(busy1), .done(done1),
    .wr_reject(rej1), .txd(txd1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [15:0] ref_buf [W];
  logic [7:0]  exp_q [$];

  // Observed traffic.
  logic [7:0] rx0 [$];
  logic [7:0] rx1 [$];
  int         st0 [$];
  int         st1 [$];
  int         done_n0, done_n1, done_cyc0, done_cyc1, rej_n0, rej_n1;
  int         t_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Decode 8N1 bytes from one instance, sampling mid-bit on negedges.
  task automatic mon(input int sel);
    logic [7:0] b;
    int         t;
    forever begin
      @(negedge clk);
      if (((sel == 0) ? txd0 : txd1) === 1'b0) begin
        t = cyc;
        for (int i = 0; i < 8; i++) begin
          repeat ((i == 0) ? (C + C / 2) : C) @(negedge clk);
          b[i] = (sel == 0) ? txd0 : txd1;
        end
        repeat (C) @(negedge clk);
        check((sel == 0) ? "stop_bit0" : "stop_bit1", {31'd0, ((sel == 0) ? txd0 : txd1)}, 32'd1);
        if (sel == 0) begin rx0.push_back(b); st0.push_back(t); end
        else          begin rx1.push_back(b); st1.push_back(t); end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  // Pulse counters for done and wr_reject.
  initial forever begin
    @(negedge clk);
    if (done0 === 1'b1) begin done_n0++; done_cyc0 = cyc; end
    if (done1 === 1'b1) begin done_n1++; done_cyc1 = cyc; end
    if (rej0 === 1'b1) rej_n0++;
    if (rej1 === 1'b1) rej_n1++;
  end

  // Expected frame from the word buffer: raw length, then every word low byte first.
  function automatic void build_exp(input logic [7:0] len);
    int          eff;
    logic [15:0] w;
    eff = (len == 8'd0 || int'(len) > W) ? W : int'(len);
    exp_q.delete();
    exp_q.push_back(len);
    for (int k = 0; k < W; k++) begin
      w = (k < eff) ? ref_buf[k] : 16'h0000;
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endfunction

  task automatic write_word(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    ref_buf[a] = d;
  endtask

  task automatic clear_obs();
    rx0.delete(); rx1.delete(); st0.delete(); st1.delete();
    done_n0 = 0; done_n1 = 0; rej_n0 = 0; rej_n1 = 0;
  endtask

  // Start a frame; optionally write a word in the same cycle as start.
  task automatic start_frame(input logic [7:0] len, input bit with_wr,
                             input logic [5:0] a, input logic [15:0] d);
    clear_obs();
    @(negedge clk);
    payload_len = len; start = 1'b1;
    if (with_wr) begin wr_en = 1'b1; wr_addr = a; wr_data = d; ref_buf[a] = d; end
    build_exp(len);
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    t_busy = cyc;
    check("busy_rise0", {31'd0, busy0}, 32'd1);
    check("busy_rise1", {31'd0, busy1}, 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    int guard;
    int bad0, bad1, sp0, sp1;
    guard = 0;
    while ((done_n0 == 0 || done_n1 == 0) && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_timeout"}, {31'd0, guard < 8000}, 32'd1);
    repeat (4) @(negedge clk);
    check({tag, "_nbytes0"}, rx0.size(), NB);
    check({tag, "_nbytes1"}, rx1.size(), NB);
    bad0 = 0; bad1 = 0; sp0 = 0; sp1 = 0;
    for (int i = 0; i < NB; i++) begin
      if (i >= rx0.size() || rx0[i] !== exp_q[i]) bad0++;
      if (i >= rx1.size() || rx1[i] !== exp_q[i]) bad1++;
    end
    if (rx0.size() > 0) check({tag, "_hdr0"}, {24'd0, rx0[0]}, {24'd0, exp_q[0]});
    check({tag, "_bad_bytes0"}, bad0, 0);
    check({tag, "_bad_bytes1"}, bad1, 0);
    check({tag, "_done_cnt0"}, done_n0, 1);
    check({tag, "_done_cnt1"}, done_n1, 1);
    check({tag, "_done_lat0"}, done_cyc0 - t_busy, NB * P0);
    check({tag, "_done_lat1"}, done_cyc1 - t_busy, NB * P1 - 3);
    if (st0.size() == NB && st1.size() == NB) begin
      check({tag, "_first_start0"}, st0[0] - t_busy, 1);
      check({tag, "_first_start1"}, st1[0] - t_busy, 1);
      for (int i = 1; i < NB; i++) begin
        if (st0[i] - st0[i-1] != P0) sp0++;
        if (st1[i] - st1[i-1] != P1) sp1++;
      end
      check({tag, "_spacing0"}, sp0, 0);
      check({tag, "_spacing1"}, sp1, 0);
      check({tag, "_tail0"}, done_cyc0 - st0[NB-1], 10 * C);
      check({tag, "_tail1"}, done_cyc1 - st1[NB-1], 10 * C);
    end
    $display("frame %s hdr=0x%02h bytes=%0d/%0d done_lat=%0d/%0d bad=%0d/%0d",
             tag, exp_q[0], rx0.size(), rx1.size(), done_cyc0 - t_busy,
             done_cyc1 - t_busy, bad0, bad1);
  endtask

  initial begin
    int guard;
    logic [7:0] rl;
    for (int k = 0; k < W; k++) ref_buf[k] = 16'h0000;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_rej",  {31'd0, rej0}, 32'd0);
    check("rst_txd0", {31'd0, txd0}, 32'd1);
    check("rst_txd1", {31'd0, txd1}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rel_done", {31'd0, done0}, 32'd0);
    check("rel_rej",  {31'd0, rej0}, 32'd0);
    check("rel_txd",  {31'd0, txd0}, 32'd1);

    // 1: incrementing words, full length.
    for (int k = 0; k < W; k++) write_word(6'(k), 16'h0100 + 16'(k));
    start_frame(8'd64, 1'b0, 6'd0, 16'h0);
    finish_frame("t1_len64");

    // 2: same buffer, short length pads with zeros.
    start_frame(8'd16, 1'b0, 6'd0, 16'h0);
    finish_frame("t2_len16");

    // 3: random buffer, length 0 and over-range both send all words.
    for (int k = 0; k < W; k++) write_word(6'(k), 16'($urandom));
    start_frame(8'd0, 1'b0, 6'd0, 16'h0);
    finish_frame("t3_len0");
    start_frame(8'd200, 1'b0, 6'd0, 16'h0);
    finish_frame("t3_len200");

    // Random length with a write landing in the same cycle as start.
    rl = 8'($urandom_range(1, 63));
    start_frame(rl, 1'b1, 6'(rl - 8'd1), 16'($urandom));
    finish_frame("rand_len");

    // 4: start and write while busy are ignored; write is flagged once.
    start_frame(8'd64, 1'b0, 6'd0, 16'h0);
    repeat (300) @(negedge clk);
    start = 1'b1; wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'hBEEF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check("t4_rej_pulse", {31'd0, rej0}, 32'd1);
    finish_frame("t4_busy");
    check("t4_rej_cnt0", rej_n0, 1);
    check("t4_rej_cnt1", rej_n1, 1);
    start_frame(8'd64, 1'b0, 6'd0, 16'h0);
    finish_frame("t4_next");
    check("t4_next_rej", rej_n0, 0);

    // 5: reset during byte 50, then a frame of zeros.
    start_frame(8'd64, 1'b0, 6'd0, 16'h0);
    guard = 0;
    while (rx0.size() < 50 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("t5_reach_b50", {31'd0, guard < 4000}, 32'd1);
    repeat (4 * C) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_txd0",  {31'd0, txd0}, 32'd1);
    check("t5_txd1",  {31'd0, txd1}, 32'd1);
    check("t5_busy0", {31'd0, busy0}, 32'd0);
    check("t5_busy1", {31'd0, busy1}, 32'd0);
    for (int k = 0; k < W; k++) ref_buf[k] = 16'h0000;
    repeat (60) @(negedge clk);
    check("t5_no_done0", done_n0, 0);
    check("t5_no_done1", done_n1, 0);
    check("t5_no_rej", rej_n0, 0);
    start_frame(8'd64, 1'b0, 6'd0, 16'h0);
    finish_frame("t5_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
